// File: rtl/frame_spill_ctrl_pkg.sv
// frame_spill_ctrl_pkg: shared FSM states, op encoding, special register indices and popcount helper
package frame_spill_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, ACCESS, WB, FINISH} state_t;
  localparam logic OP_SAVE = 1'b0;
  localparam logic OP_RESTORE = 1'b1;
  localparam logic [3:0] FB_REG = 4'hd;
  localparam logic [3:0] ACC_REG = 4'hf;
  function automatic logic [3:0] popcount8(input logic [7:0] m);
    popcount8 = '0;
    for (int j = 0; j < 8; j++) popcount8 = popcount8 + {3'd0, m[j]};
  endfunction
endpackage

// File: rtl/frame_spill_ctrl_lowest_bit_finder.sv
// lowest_bit_finder: index of the lowest set bit of an 8-bit mask
//   mask  in  8 : candidate bits
//   idx   out 3 : index of the lowest set bit (0 when mask is empty)
//   valid out 1 : mask has at least one bit set
module lowest_bit_finder (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       valid
);
  always_comb begin
    idx = '0;
    for (int j = 7; j >= 0; j--) if (mask[j]) idx = 3'(j);
  end
  assign valid = |mask;
endmodule

// File: rtl/frame_spill_ctrl.sv
// frame_spill_ctrl: saves/restores masked registers r0..r7 to/from a frame below/above r13
//   clk, rst_n                 : clock, async active-low reset
//   start, op, mask, fb_in     : request, 0=save 1=restore, register mask, current r13
//   busy, done, fb_we, fb_wdata: status, completion pulse, r13 update
//   rf_addr/rf_rdata/rf_we/rf_wdata          : register-file port (read is combinational)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata : memory port, request held until ack
module frame_spill_ctrl
  import frame_spill_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [7:0]        mask,
  input  logic [ADDR_W-1:0] fb_in,
  output logic              busy,
  output logic              done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_wdata,
  output logic [3:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state;
  logic op_r;
  logic [7:0] mask_r, mask_clr, f_in;
  logic [ADDR_W-1:0] fb_r, n_a, k_a;
  logic [3:0] n, k, nxt_addr;
  logic [2:0] cur, f_idx;
  logic f_v;
  assign mask_clr = mask_r & ~(8'd1 << cur);
  // The finder looks at the mask the FSM is about to hold, so rf_addr is
  // already registered to the visited register when SCAN samples rf_rdata.
  assign f_in = state == IDLE ? mask : state == ACCESS ? mask_clr : mask_r;
  assign nxt_addr = f_v ? {1'b0, f_idx} : ACC_REG;
  assign n_a = ADDR_W'(n);
  assign k_a = ADDR_W'(k);
  lowest_bit_finder u_lbf (.mask(f_in), .idx(f_idx), .valid(f_v));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_r <= OP_SAVE;
      mask_r <= '0;
      fb_r <= '0;
      n <= '0;
      k <= '0;
      cur <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fb_we <= 1'b0;
      fb_wdata <= '0;
      rf_addr <= ACC_REG;
      rf_we <= 1'b0;
      rf_wdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            op_r <= op;
            mask_r <= mask;
            fb_r <= fb_in;
            n <= popcount8(mask);
            k <= '0;
            cur <= f_idx;
            rf_addr <= nxt_addr;
            busy <= 1'b1;
            state <= SCAN;
          end
        SCAN: begin
          rf_addr <= ACC_REG;
          if (mask_r == '0) begin
            done <= 1'b1;
            fb_we <= 1'b1;
            fb_wdata <= op_r == OP_RESTORE ? fb_r + n_a : fb_r - n_a;
            state <= FINISH;
          end else begin
            mem_req <= 1'b1;
            mem_we <= op_r == OP_SAVE;
            mem_addr <= op_r == OP_RESTORE ? fb_r + k_a : fb_r - n_a + k_a;
            mem_wdata <= op_r == OP_SAVE ? rf_rdata : '0;
            state <= ACCESS;
          end
        end
        ACCESS:
          if (mem_ack) begin
            mask_r <= mask_clr;
            k <= k + 4'd1;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            if (op_r == OP_SAVE) begin
              cur <= f_idx;
              rf_addr <= nxt_addr;
              state <= SCAN;
            end else begin
              rf_we <= 1'b1;
              rf_addr <= {1'b0, cur};
              rf_wdata <= mem_rdata;
              state <= WB;
            end
          end
        WB: begin
          rf_we <= 1'b0;
          rf_wdata <= '0;
          cur <= f_idx;
          rf_addr <= nxt_addr;
          state <= SCAN;
        end
        FINISH: begin
          done <= 1'b0;
          fb_we <= 1'b0;
          fb_wdata <= '0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_frame_spill_ctrl.sv
// tb_frame_spill_ctrl: scoreboard bench for frame_spill_ctrl with a delayed-ack memory responder
module tb_frame_spill_ctrl;
  import frame_spill_ctrl_pkg::*;
  localparam int DW = 8;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst_n, start, op;
  logic [7:0] mask;
  logic [AW-1:0] fb_in, fb_wdata, mem_addr;
  logic busy, done, fb_we, rf_we, mem_req, mem_we, mem_ack;
  logic [3:0] rf_addr;
  logic [DW-1:0] rf_rdata, rf_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] regs [16];
  logic [DW-1:0] mem [256];
  typedef struct {int kind; int addr; int data; int cyc;} ev_t;
  ev_t q[$];
  int tests = 0, fails = 0, cyc = 0, ack_delay = 0;
  always #5 clk = ~clk;
  assign rf_rdata = regs[rf_addr];
  frame_spill_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .mask(mask), .fb_in(fb_in),
    .busy(busy), .done(done), .fb_we(fb_we), .fb_wdata(fb_wdata),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic ex(int k, int a, int d, int c);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.cyc = c;
    q.push_back(e);
  endtask
  // kind: 0 mem write, 1 mem read, 2 rf write, 3 done (data = fb_we)
  task automatic got(int k, int a, int d);
    ev_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: kind %0d addr %0h data %0h at cycle %0d", k, a, d, cyc);
    end else begin
      e = q.pop_front();
      chk("ev_kind", k, e.kind);
      chk("ev_addr", a, e.addr);
      if (e.kind != 1) chk("ev_data", d, e.data);
      if (e.cyc >= 0) chk("ev_cycle", cyc, e.cyc);
    end
  endtask
  task automatic do_start(logic o, logic [7:0] m, logic [AW-1:0] f, output int s);
    @(negedge clk);
    start = 1'b1;
    op = o;
    mask = m;
    fb_in = f;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(string nm);
    int t = 0;
    while ((busy || q.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain"}, (busy || q.size() != 0) ? 1 : 0, 0);
  endtask
  initial forever @(posedge clk) cyc++;
  // memory responder: acks after ack_delay waiting cycles of a held request
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && rst_n) begin
        if (cnt == ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          cnt = 0;
        end else begin
          mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end
  // monitor: pops the scoreboard on every observable DUT event, checks stall stability
  initial begin
    logic pend, pw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend) begin
          chk("stall_req", mem_req, 1);
          chk("stall_addr", mem_addr, pa);
          chk("stall_wdata", mem_wdata, pd);
          chk("stall_we", mem_we, pw);
        end
        if (mem_req && mem_ack) got(mem_we ? 0 : 1, mem_addr, mem_wdata);
        if (rf_we) got(2, rf_addr, rf_wdata);
        if (done) got(3, fb_wdata, fb_we);
        pend = mem_req && !mem_ack;
        pa = mem_addr;
        pd = mem_wdata;
        pw = mem_we;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int s;
    rst_n = 1'b0;
    start = 1'b0;
    op = 1'b0;
    mask = '0;
    fb_in = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rf_addr", rf_addr, ACC_REG);
    rst_n = 1'b1;
    @(negedge clk);
    regs[0] = 8'h11;
    regs[2] = 8'h22;
    do_start(OP_SAVE, 8'h05, 8'h80, s);
    ex(0, 'h7E, 'h11, -1);
    ex(0, 'h7F, 'h22, -1);
    ex(3, 'h7E, 1, s + 6);
    wait_idle("save");
    regs[0] = 8'h00;
    regs[2] = 8'h00;
    mem['h7E] = 8'h11;
    mem['h7F] = 8'h22;
    do_start(OP_RESTORE, 8'h05, 8'h7E, s);
    ex(1, 'h7E, 0, -1);
    ex(2, 0, 'h11, -1);
    ex(1, 'h7F, 0, -1);
    ex(2, 2, 'h22, -1);
    ex(3, 'h80, 1, s + 8);
    wait_idle("restore");
    do_start(OP_SAVE, 8'h00, 8'h42, s);
    ex(3, 'h42, 1, s + 2);
    wait_idle("empty");
    for (int i = 0; i < 4; i++) regs[i] = 8'hA0 + 8'(i);
    do_start(OP_SAVE, 8'h0F, 8'h01, s);
    ex(0, 'hFD, 'hA0, -1);
    ex(0, 'hFE, 'hA1, -1);
    ex(0, 'hFF, 'hA2, -1);
    ex(0, 'h00, 'hA3, -1);
    ex(3, 'hFD, 1, s + 10);
    wait_idle("wrap");
    ack_delay = 3;
    regs[7] = 8'h77;
    do_start(OP_SAVE, 8'h80, 8'h20, s);
    ex(0, 'h1F, 'h77, -1);
    ex(3, 'h1F, 1, s + 7);
    @(negedge clk);
    start = 1'b1;
    op = OP_RESTORE;
    mask = 8'hFF;
    fb_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_idle("stall");
    ack_delay = 10;
    regs[1] = 8'h5A;
    do_start(OP_SAVE, 8'h02, 8'h30, s);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("rst_wait_req", mem_req, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_done", done, 0);
    chk("abort_fb_we", fb_we, 0);
    chk("abort_rf_we", rf_we, 0);
    chk("abort_rf_addr", rf_addr, ACC_REG);
    repeat (2) @(negedge clk);
    ack_delay = 0;
    rst_n = 1'b1;
    do_start(OP_SAVE, 8'h02, 8'h30, s);
    ex(0, 'h2F, 'h5A, -1);
    ex(3, 'h2F, 1, s + 4);
    wait_idle("after_reset");
    repeat (3) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_spill_ctrl.md
FRAME_SPILL_CTRL -- requirements
Module: frame_spill_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register and memory data width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning memory address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk in 1 (rising edge), rst_n in 1 (async, active-low).
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
- start in 1: request pulse; sampled only in IDLE.
- op in 1: operation select; 0 = save, 1 = restore.
- mask in 8: bit i set = visit register ri (r0..r7).
- fb_in in ADDR_W: current frame base (r13) value.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle completion pulse.
- fb_we out 1: r13 write enable.
- fb_wdata out ADDR_W: new r13 value.
- rf_addr out 4: register-file read/write index.
- rf_rdata in DATA_W: register-file read data, combinational from rf_addr.
- rf_we out 1: register-file write enable.
- rf_wdata out DATA_W: register-file write data.
- mem_req out 1: memory request.
- mem_we out 1: 1 = write, 0 = read.
- mem_addr out ADDR_W: memory address.
- mem_wdata out DATA_W: memory write data.
- mem_ack in 1: memory completion; ends the current request.
- mem_rdata in DATA_W: memory read data, valid with mem_ack.

Function
REQ-005 SHALL implement states IDLE, SCAN, ACCESS, WB and FINISH.
REQ-006 IDLE + start=1 SHALL latch op, mask, fb_in and n = popcount(mask), clear index k, and go to SCAN next cycle.
REQ-007 start while busy=1 SHALL be ignored, with no latching and no effect.
REQ-008 SCAN SHALL select the lowest set bit i of the latched mask and drive rf_addr=i.
- If no bit is set, go to FINISH.
- On save, capture rf_rdata into a data register, then go to ACCESS.
REQ-009 ACCESS SHALL hold mem_req=1 with stable mem_we, mem_addr and mem_wdata until the cycle mem_ack=1.
REQ-010 Save address SHALL be fb - n + k; restore address SHALL be fb + k; both truncate modulo 2^ADDR_W.
REQ-011 On mem_ack in ACCESS, the controller SHALL clear bit i and increment k.
- Save: go to SCAN.
- Restore: capture mem_rdata and go to WB.
REQ-012 WB SHALL assert rf_we=1 for exactly one cycle with rf_addr=i and rf_wdata=captured data, then go to SCAN.
REQ-013 FINISH SHALL assert done=1 and fb_we=1 for one cycle, then go to IDLE.
- Save: fb_wdata = fb - n.
- Restore: fb_wdata = fb + n.
REQ-014 Registers SHALL be visited in ascending index order.
- mask=0 completes with done in the second cycle after start, and fb is unchanged.
REQ-015 mem_ack outside ACCESS SHALL be ignored.
REQ-016 When not otherwise driven, rf_addr SHALL be 4'hf (accumulator); mem_*, rf_we and fb_we SHALL be 0.

Reset
REQ-017 rst_n=0 SHALL asynchronously force:
- state IDLE;
- busy, done, fb_we, rf_we and mem_req 0;
- rf_addr 4'hf;
- all latched data, mask, n and k cleared.
REQ-018 Reset asserted mid-operation SHALL abort the operation with no done pulse and no r13 update.
- Any accepted memory requests remain accepted.

Structure
REQ-019 The state enum, the op encoding (OP_SAVE=0, OP_RESTORE=1), FB_REG=4'hd and ACC_REG=4'hf SHALL live in the shared package.
REQ-020 A combinational sub-module, lowest_bit_finder (8-bit mask in, 3-bit index plus valid out), SHALL be used for SCAN.

Verification
REQ-021 Save: fb_in=0x80, mask=0x05, r0=0x11, r2=0x22, immediate ack.
- Writes 0x11@0x7E, then 0x22@0x7F.
- fb_wdata=0x7E.
- done on cycle 6.
REQ-022 Restore: fb_in=0x7E, mask=0x05, mem[0x7E]=0x11, mem[0x7F]=0x22.
- rf writes r0=0x11, then r2=0x22.
- fb_wdata=0x80.
REQ-023 Empty mask, start at cycle 0:
- done and fb_we at cycle 2.
- fb_wdata=fb_in.
- No mem_req.
REQ-024 Wrap: save with fb_in=0x01, mask=0x0F.
- Addresses 0xFD, 0xFE, 0xFF, 0x00.
- fb_wdata=0xFD.
REQ-025 Stall: mem_ack delayed 3 cycles.
- mem_req, mem_addr and mem_wdata stay stable.
- A start pulse during the stall is ignored.
REQ-026 rst_n low during ACCESS:
- Outputs go to reset values immediately.
- No done; the next start works normally.
